prio_arbiter: RTL and testbench

PRIO_ARBITER -- requirements
Module: prio_arbiter

---
 rtl/arb_pkg.sv | 14 +
 rtl/arb_pick.sv | 32 +++
 rtl/prio_arbiter.sv | 142 ++++++++++++++
 tb/tb_prio_arbiter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the priority/round-robin arbiter.
package arb_pkg;

   localparam int ARB_N_REQ_DEF = 8;
   localparam int ARB_ID_W      = $clog2(ARB_N_REQ_DEF);
   localparam int ARB_HOLD_W    = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } ArbState;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner search: scans requests downward from a start index,
// wrapping past zero, and reports the first set index found.
module arb_pick
   import arb_pkg::*;
#(
   parameter int N_REQ = ARB_N_REQ_DEF
) (
   input  logic [N_REQ-1:0]         req_i,
   input  logic [$clog2(N_REQ)-1:0] start_i,
   output logic [$clog2(N_REQ)-1:0] idx_o,
   output logic                     found_o
);

   localparam int W = $clog2(N_REQ);

   logic [W-1:0] scanIdx;

   // Walk start, start-1, ... with wrap; the first requester hit wins
   always_comb begin
      idx_o   = '0;
      found_o = 1'b0;
      scanIdx = '0;
      for (int k = 0; k < N_REQ; k++) begin
         scanIdx = W'((int'(start_i) + N_REQ - k) % N_REQ);
         if (!found_o && req_i[scanIdx]) begin
            found_o = 1'b1;
            idx_o   = scanIdx;
         end
      end
   end

endmodule

// File: rtl/prio_arbiter.sv
// Fixed-priority / round-robin arbiter with bounded grant hold time and a
// one-cycle dead gap between consecutive grants.
module prio_arbiter
   import arb_pkg::*;
#(
   parameter int N_REQ    = ARB_N_REQ_DEF,
   parameter int RR_MODE  = 0,
   parameter int MAX_HOLD = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req,
   input  logic                     done,
   output logic [N_REQ-1:0]         gnt,
   output logic [$clog2(N_REQ)-1:0] gnt_id,
   output logic                     gnt_valid,
   output logic                     timeout
);

   localparam int IdW = $clog2(N_REQ);
   localparam logic [ARB_HOLD_W-1:0] MaxHoldC = ARB_HOLD_W'(MAX_HOLD);

   ArbState                state_q, state_d;
   logic [N_REQ-1:0]       gnt_q, gnt_d;
   logic [IdW-1:0]         gntId_q, gntId_d;
   logic                   valid_q, valid_d;
   logic                   timeout_q, timeout_d;
   logic [ARB_HOLD_W-1:0]  hold_q, hold_d;
   logic [IdW-1:0]         lastId_q, lastId_d;

   logic [IdW-1:0]         pickStart;
   logic [IdW-1:0]         pickIdx;
   logic                   pickFound;
   logic                   holdExpired;
   logic                   releaseNow;

   // Fixed mode always scans from the top; round-robin starts one below the
   // last winner so the previous grantee becomes lowest priority
   always_comb begin
      pickStart = IdW'(N_REQ - 1);
      if (RR_MODE != 0) begin
         pickStart = (lastId_q == '0) ? IdW'(N_REQ - 1) : (lastId_q - IdW'(1));
      end
   end

   arb_pick #(
      .N_REQ (N_REQ)
   ) uPick (
      .req_i   (req),
      .start_i (pickStart),
      .idx_o   (pickIdx),
      .found_o (pickFound)
   );

   assign holdExpired = (hold_q == MaxHoldC);
   assign releaseNow  = done || !req[gntId_q] || holdExpired;

   // State register; reset drops straight to IDLE without passing through GAP
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Arbitration happens in IDLE and in the single GAP cycle, so grants are
   // separated by exactly one dead cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, GAP: state_d = pickFound ? GRANT : IDLE;
         GRANT:     if (releaseNow) state_d = GAP;
         default:   state_d = IDLE;
      endcase
   end

   // Next values for the registered outputs and bookkeeping; grant fields are
   // frozen while granting and gnt_id keeps the last winner after release
   always_comb begin
      gnt_d     = gnt_q;
      gntId_d   = gntId_q;
      valid_d   = valid_q;
      timeout_d = 1'b0;
      hold_d    = hold_q;
      lastId_d  = lastId_q;
      case (state_q)
         IDLE, GAP: begin
            gnt_d   = '0;
            valid_d = 1'b0;
            hold_d  = '0;
            if (pickFound) begin
               gnt_d[pickIdx] = 1'b1;
               gntId_d        = pickIdx;
               valid_d        = 1'b1;
               hold_d         = ARB_HOLD_W'(1);
               lastId_d       = pickIdx;
            end
         end
         GRANT: begin
            if (releaseNow) begin
               gnt_d     = '0;
               valid_d   = 1'b0;
               hold_d    = '0;
               timeout_d = holdExpired && !done;
            end else begin
               hold_d = hold_q + ARB_HOLD_W'(1);
            end
         end
         default: begin
            gnt_d   = '0;
            valid_d = 1'b0;
            hold_d  = '0;
         end
      endcase
   end

   // Output and bookkeeping registers; every output comes straight from here
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_q     <= '0;
         gntId_q   <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         hold_q    <= '0;
         lastId_q  <= '0;
      end else begin
         gnt_q     <= gnt_d;
         gntId_q   <= gntId_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
         hold_q    <= hold_d;
         lastId_q  <= lastId_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_id    = gntId_q;
   assign gnt_valid = valid_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_prio_arbiter.sv
// Directed scoreboard bench for prio_arbiter: one fixed-priority instance,
// one round-robin instance and one fixed instance with a short hold limit.
module tb_prio_arbiter;
   import arb_pkg::*;

   typedef struct {
      int                  dut;
      string               tag;
      logic [7:0]          gnt;
      logic [ARB_ID_W-1:0] id;
      logic                valid;
      logic                tmo;
   } ExpItem;

   logic clk;
   logic rst_n;

   logic [7:0]          reqA, reqB, reqC;
   logic                doneA, doneB, doneC;
   logic [7:0]          gntA, gntB, gntC;
   logic [ARB_ID_W-1:0] idA, idB, idC;
   logic                validA, validB, validC;
   logic                tmoA, tmoB, tmoC;

   ExpItem sbQ[$];
   int     checks = 0;
   int     errors = 0;

   prio_arbiter #(.N_REQ(8), .RR_MODE(0), .MAX_HOLD(16)) dutFixed (
      .clk(clk), .rst_n(rst_n), .req(reqA), .done(doneA),
      .gnt(gntA), .gnt_id(idA), .gnt_valid(validA), .timeout(tmoA)
   );

   prio_arbiter #(.N_REQ(8), .RR_MODE(1), .MAX_HOLD(16)) dutRr (
      .clk(clk), .rst_n(rst_n), .req(reqB), .done(doneB),
      .gnt(gntB), .gnt_id(idB), .gnt_valid(validB), .timeout(tmoB)
   );

   prio_arbiter #(.N_REQ(8), .RR_MODE(0), .MAX_HOLD(4)) dutHold (
      .clk(clk), .rst_n(rst_n), .req(reqC), .done(doneC),
      .gnt(gntC), .gnt_id(idC), .gnt_valid(validC), .timeout(tmoC)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic applyStimulus(input int dut, input logic [7:0] r, input logic d);
      case (dut)
         0:       begin reqA = r; doneA = d; end
         1:       begin reqB = r; doneB = d; end
         default: begin reqC = r; doneC = d; end
      endcase
   endtask

   task automatic expectOut(input int dut, input string tag, input logic [7:0] g,
                            input int id, input logic v, input logic t);
      ExpItem e;
      e.dut   = dut;
      e.tag   = tag;
      e.gnt   = g;
      e.id    = ARB_ID_W'(id);
      e.valid = v;
      e.tmo   = t;
      sbQ.push_back(e);
   endtask

   task automatic checkOutput();
      ExpItem              e;
      logic [7:0]          g;
      logic [ARB_ID_W-1:0] id;
      logic                v;
      logic                t;
      e = sbQ.pop_front();
      case (e.dut)
         0:       begin g = gntA; id = idA; v = validA; t = tmoA; end
         1:       begin g = gntB; id = idB; v = validB; t = tmoB; end
         default: begin g = gntC; id = idC; v = validC; t = tmoC; end
      endcase
      checks++;
      assert ({g, id, v, t} === {e.gnt, e.id, e.valid, e.tmo}) else begin
         errors++;
         $error("[TB] FAIL %s dut%0d observed gnt=%h id=%0d valid=%b timeout=%b expected gnt=%h id=%0d valid=%b timeout=%b",
                e.tag, e.dut, g, id, v, t, e.gnt, e.id, e.valid, e.tmo);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      tick();
      checkOutput();
   endtask

   // Directed sequence: reset, fixed priority, hold limit, round-robin, async reset
   initial begin
      int         rrSeq [9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
      logic [7:0] oh;

      rst_n = 1'b0;
      applyStimulus(0, 8'h00, 1'b0);
      applyStimulus(1, 8'h00, 1'b0);
      applyStimulus(2, 8'h00, 1'b0);
      tick();
      tick();
      expectOut(0, "reset_fixed", 8'h00, 0, 1'b0, 1'b0); checkOutput();
      expectOut(1, "reset_rr",    8'h00, 0, 1'b0, 1'b0); checkOutput();
      expectOut(2, "reset_hold",  8'h00, 0, 1'b0, 1'b0); checkOutput();
      rst_n = 1'b1;

      // Fixed priority: highest index wins, one gap cycle, then next winner
      applyStimulus(0, 8'h28, 1'b0); expectOut(0, "fix_first",     8'h20, 5, 1'b1, 1'b0); step();
      applyStimulus(0, 8'h08, 1'b1); expectOut(0, "fix_done_gap",  8'h00, 5, 1'b0, 1'b0); step();
      applyStimulus(0, 8'h08, 1'b0); expectOut(0, "fix_second",    8'h08, 3, 1'b1, 1'b0); step();
      applyStimulus(0, 8'h88, 1'b0); expectOut(0, "fix_req_change",8'h08, 3, 1'b1, 1'b0); step();
      applyStimulus(0, 8'h00, 1'b1); expectOut(0, "fix_release",   8'h00, 3, 1'b0, 1'b0); step();
      applyStimulus(0, 8'h00, 1'b0); expectOut(0, "fix_idle_id",   8'h00, 3, 1'b0, 1'b0); step();
      applyStimulus(0, 8'h00, 1'b1); expectOut(0, "fix_done_idle", 8'h00, 3, 1'b0, 1'b0); step();
      applyStimulus(0, 8'h04, 1'b0); expectOut(0, "fix_grant2",    8'h04, 2, 1'b1, 1'b0); step();
      applyStimulus(0, 8'h04, 1'b0); expectOut(0, "fix_hold2",     8'h04, 2, 1'b1, 1'b0); step();
      applyStimulus(0, 8'h00, 1'b0); expectOut(0, "fix_abandon",   8'h00, 2, 1'b0, 1'b0); step();
      applyStimulus(0, 8'h00, 1'b1); expectOut(0, "fix_done_after",8'h00, 2, 1'b0, 1'b0); step();
      applyStimulus(0, 8'h00, 1'b0);

      // Hold limit 4: done on the last allowed cycle releases without timeout
      applyStimulus(2, 8'h01, 1'b0); expectOut(2, "hold_g1", 8'h01, 0, 1'b1, 1'b0); step();
      for (int h = 2; h <= 4; h++) begin
         expectOut(2, "hold_gn", 8'h01, 0, 1'b1, 1'b0); step();
      end
      applyStimulus(2, 8'h01, 1'b1); expectOut(2, "hold_done_at_max", 8'h00, 0, 1'b0, 1'b0); step();
      // No done: four grant cycles, single timeout pulse, then regrant
      applyStimulus(2, 8'h01, 1'b0); expectOut(2, "hold_regrant1", 8'h01, 0, 1'b1, 1'b0); step();
      for (int h = 2; h <= 4; h++) begin
         expectOut(2, "hold_gn2", 8'h01, 0, 1'b1, 1'b0); step();
      end
      expectOut(2, "hold_timeout",  8'h00, 0, 1'b0, 1'b1); step();
      expectOut(2, "hold_regrant2", 8'h01, 0, 1'b1, 1'b0); step();
      applyStimulus(2, 8'h00, 1'b0); expectOut(2, "hold_drop", 8'h00, 0, 1'b0, 1'b0); step();

      // Round-robin rotation with all requesters active
      applyStimulus(1, 8'hFF, 1'b0);
      for (int i = 0; i < 9; i++) begin
         oh = 8'h01 << rrSeq[i];
         expectOut(1, "rr_grant", oh, rrSeq[i], 1'b1, 1'b0); step();
         applyStimulus(1, 8'hFF, 1'b1);
         expectOut(1, "rr_gap", 8'h00, rrSeq[i], 1'b0, 1'b0); step();
         applyStimulus(1, 8'hFF, 1'b0);
      end
      applyStimulus(1, 8'h81, 1'b0); expectOut(1, "rr_wrap",     8'h01, 0, 1'b1, 1'b0); step();
      applyStimulus(1, 8'h09, 1'b1); expectOut(1, "rr_wrap_gap", 8'h00, 0, 1'b0, 1'b0); step();
      applyStimulus(1, 8'h09, 1'b0); expectOut(1, "rr_from_top", 8'h08, 3, 1'b1, 1'b0); step();

      // Asynchronous reset mid-grant, then pointer restarts at the top
      applyStimulus(1, 8'h80, 1'b0);
      rst_n = 1'b0;
      #1;
      expectOut(1, "rst_async", 8'h00, 0, 1'b0, 1'b0); checkOutput();
      tick();
      expectOut(1, "rst_held",  8'h00, 0, 1'b0, 1'b0); checkOutput();
      rst_n = 1'b1;
      applyStimulus(1, 8'h81, 1'b0); expectOut(1, "rst_regrant", 8'h80, 7, 1'b1, 1'b0); step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
